// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: valid/ready command front-end that sequences setup/strobe/hold
// cycles on an asynchronous SRAM port (active-low enable/write) and streams read beats back.
// Optional write-verify read-back is compiled in with `define RAM_SEQ_VERIFY_EN.
module ram_access_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int WAIT   = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_rd_valid,
   input  logic              i_rd_ready,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_busy,
   output logic              o_verify_err,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic              o_ram_enable_x,
   output logic              o_ram_write_x,
   output logic [DATA_W-1:0] o_ram_data,
   input  logic [DATA_W-1:0] i_ram_data
);
   localparam int WCNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP, S_VSTROBE, S_VHOLD
   } state_t;

   state_t              r_state, w_nstate;
   logic [ADDR_W-1:0]   r_addr, w_addr;
   logic [LEN_W-1:0]    r_cnt, w_cnt;
   logic                r_write, w_write;
   logic [WCNT_W-1:0]   r_wcnt, w_wcnt;
   logic [DATA_W-1:0]   r_wdata, w_wdata;
   logic [DATA_W-1:0]   r_rd_data, w_rd_data;
   logic                r_rd_valid, w_rd_valid;
   logic                r_wr_ready, r_cmd_ready, r_busy, r_en_x, r_we_x;
   logic                w_adv, w_strobe_done;
`ifdef RAM_SEQ_VERIFY_EN
   logic                r_verr, w_verr;
   logic [DATA_W-1:0]   r_vdata, w_vdata;
`endif

   assign w_strobe_done = (r_wcnt == WCNT_W'(WAIT));

   // Next-state and next-register values; outputs are registered from the next state
   always_comb begin
      w_nstate   = r_state;
      w_addr     = r_addr;
      w_cnt      = r_cnt;
      w_write    = r_write;
      w_wcnt     = r_wcnt;
      w_wdata    = r_wdata;
      w_rd_data  = r_rd_data;
      w_rd_valid = r_rd_valid;
      w_adv      = 1'b0;
`ifdef RAM_SEQ_VERIFY_EN
      w_verr     = r_verr;
      w_vdata    = r_vdata;
`endif
      case (r_state)
         S_IDLE: if (i_cmd_valid && r_cmd_ready) begin
            w_addr   = i_cmd_addr;
            w_cnt    = i_cmd_len;
            w_write  = i_cmd_write;
            w_wcnt   = '0;
            w_nstate = S_SETUP;
`ifdef RAM_SEQ_VERIFY_EN
            w_verr   = 1'b0;
`endif
         end
         S_SETUP: begin
            if (!r_write) w_nstate = S_STROBE;
            else if (i_wr_valid && r_wr_ready) begin
               w_wdata  = i_wr_data;
               w_nstate = S_STROBE;
            end
         end
         S_STROBE: begin
            if (w_strobe_done) begin
               w_wcnt = '0;
               if (r_write) w_nstate = S_HOLD;
               else begin
                  // async RAM output has settled by the last strobe cycle
                  w_rd_data  = i_ram_data;
                  w_rd_valid = 1'b1;
                  w_nstate   = S_RESP;
               end
            end else w_wcnt = r_wcnt + 1'b1;
         end
`ifdef RAM_SEQ_VERIFY_EN
         S_HOLD: w_nstate = S_VSTROBE;
         S_VSTROBE: begin
            if (w_strobe_done) begin
               w_wcnt   = '0;
               w_vdata  = i_ram_data;
               w_nstate = S_VHOLD;
            end else w_wcnt = r_wcnt + 1'b1;
         end
         S_VHOLD: begin
            if (r_vdata != r_wdata) w_verr = 1'b1;
            w_adv = 1'b1;
         end
`else
         S_HOLD: w_adv = 1'b1;
`endif
         S_RESP: if (i_rd_ready) begin
            w_rd_valid = 1'b0;
            w_adv      = 1'b1;
         end
         default: w_nstate = S_IDLE;
      endcase
      // beat finished: next address (wrapping) or back to idle
      if (w_adv) begin
         if (r_cnt == '0) w_nstate = S_IDLE;
         else begin
            w_addr   = r_addr + 1'b1;
            w_cnt    = r_cnt - 1'b1;
            w_nstate = S_SETUP;
         end
      end
   end

   // State and registered outputs; strobes only go low when entering a strobe state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_write     <= 1'b0;
         r_wcnt      <= '0;
         r_wdata     <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_wr_ready  <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_en_x      <= 1'b1;
         r_we_x      <= 1'b1;
`ifdef RAM_SEQ_VERIFY_EN
         r_verr      <= 1'b0;
         r_vdata     <= '0;
`endif
      end else begin
         r_state     <= w_nstate;
         r_addr      <= w_addr;
         r_cnt       <= w_cnt;
         r_write     <= w_write;
         r_wcnt      <= w_wcnt;
         r_wdata     <= w_wdata;
         r_rd_data   <= w_rd_data;
         r_rd_valid  <= w_rd_valid;
         r_wr_ready  <= (w_nstate == S_SETUP) && w_write;
         r_cmd_ready <= (w_nstate == S_IDLE);
         r_busy      <= (w_nstate != S_IDLE);
         r_en_x      <= !((w_nstate == S_STROBE) || (w_nstate == S_VSTROBE));
         r_we_x      <= !((w_nstate == S_STROBE) && w_write);
`ifdef RAM_SEQ_VERIFY_EN
         r_verr      <= w_verr;
         r_vdata     <= w_vdata;
`endif
      end
   end

   assign o_cmd_ready    = r_cmd_ready;
   assign o_wr_ready     = r_wr_ready;
   assign o_rd_valid     = r_rd_valid;
   assign o_rd_data      = r_rd_data;
   assign o_busy         = r_busy;
   assign o_ram_addr     = r_addr;
   assign o_ram_enable_x = r_en_x;
   assign o_ram_write_x  = r_we_x;
   assign o_ram_data     = r_wdata;
`ifdef RAM_SEQ_VERIFY_EN
   assign o_verify_err   = r_verr;
`else
   assign o_verify_err   = 1'b0;
`endif
endmodule
